// File: rtl/debug_step_ctrl_if.sv
// Front-panel signal bundle for debug_step_ctrl.
// Optional macro: AUTO_RUN_EN adds the raw auto-run switch `run`.
// Handshake: none. The raw inputs are level signals, asynchronous to the
// clock, and are sampled continuously. `step` is a single-cycle strobe that
// needs no acknowledge. `switch` and `step_count` are registered levels.
// `dbg_state` exposes the button FSM state for observation.
interface debug_step_ctrl_if;
  logic        btn_step;
  logic [5:0]  sw_raw;
`ifdef AUTO_RUN_EN
  logic        run;
`endif
  logic        step;
  logic [5:0]  switch;
  logic [15:0] step_count;
  logic [1:0]  dbg_state;

`ifdef AUTO_RUN_EN
  modport master (output btn_step, sw_raw, run,
                  input  step, switch, step_count, dbg_state);
  modport slave  (input  btn_step, sw_raw, run,
                  output step, switch, step_count, dbg_state);
`else
  modport master (output btn_step, sw_raw,
                  input  step, switch, step_count, dbg_state);
  modport slave  (input  btn_step, sw_raw,
                  output step, switch, step_count, dbg_state);
`endif
endinterface

// File: rtl/debug_step_ctrl.sv
// Front-panel input conditioner: synchronizes and debounces the step button
// into a one-cycle step pulse, debounces the 6-bit register-select switches,
// and counts issued steps (wrapping at 16 bits).
// Optional macro: AUTO_RUN_EN adds a synced `run` switch and a free-running
// divider that issues a step every RUN_DIV cycles, masking button steps.
module debug_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int CNT_W           = 18,
  parameter int RUN_DIV         = 50000000
) (
  input  logic             clock,
  input  logic             reset,
  debug_step_ctrl_if.slave bus
);

  // Reject configurations the debounce counters cannot represent.
  if (DEBOUNCE_CYCLES < 2 || (2 ** CNT_W) <= DEBOUNCE_CYCLES || RUN_DIV < 1) begin : g_param_check
    $error("debug_step_ctrl: invalid parameter set");
  end

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_HELD         = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_bcnt, w_bcnt_nxt;
  logic             w_btn_fire;
  logic             w_step_fire;

  logic [1:0]       r_btn_sync;
  logic [5:0]       r_sw_sync1, r_sw_sync2;
  logic             w_btn_s;

  logic [5:0]       r_cand;
  logic [CNT_W-1:0] r_scnt;
  logic [5:0]       r_switch;
  logic             r_step;
  logic [15:0]      r_step_count;

  // Two-flop synchronizers for the raw button and switches.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_btn_sync <= '0;
      r_sw_sync1 <= '0;
      r_sw_sync2 <= '0;
    end else begin
      r_btn_sync <= {r_btn_sync[0], bus.btn_step};
      r_sw_sync1 <= bus.sw_raw;
      r_sw_sync2 <= r_sw_sync1;
    end
  end

  assign w_btn_s = r_btn_sync[1];

  // Button FSM state and debounce counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_bcnt  <= w_bcnt_nxt;
    end
  end

  // Button FSM next state; a step fires only on leaving PRESS_WAIT for HELD,
  // so holding the button or bouncing back from RELEASE_WAIT never repeats.
  always_comb begin
    w_state_nxt = r_state;
    w_bcnt_nxt  = r_bcnt;
    w_btn_fire  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_btn_s) begin
          w_state_nxt = S_PRESS_WAIT;
          w_bcnt_nxt  = '0;
        end
      end
      S_PRESS_WAIT: begin
        if (!w_btn_s) begin
          w_state_nxt = S_IDLE;
        end else if (r_bcnt == DEB_LAST) begin
          w_state_nxt = S_HELD;
          w_btn_fire  = 1'b1;
        end else begin
          w_bcnt_nxt = r_bcnt + 1'b1;
        end
      end
      S_HELD: begin
        if (!w_btn_s) begin
          w_state_nxt = S_RELEASE_WAIT;
          w_bcnt_nxt  = '0;
        end
      end
      S_RELEASE_WAIT: begin
        if (w_btn_s) begin
          w_state_nxt = S_HELD;
        end else if (r_bcnt == DEB_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_bcnt_nxt = r_bcnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef AUTO_RUN_EN
  localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  logic [1:0]       r_run_sync;
  logic [DIV_W-1:0] r_dcnt;
  logic             w_run_s;
  logic             w_auto_fire;

  // Two-flop synchronizer for the run switch (deliberately not debounced).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_run_sync <= '0;
    else        r_run_sync <= {r_run_sync[0], bus.run};
  end

  assign w_run_s     = r_run_sync[1];
  assign w_auto_fire = w_run_s && (r_dcnt == DIV_LAST);

  // Auto-run divider: counts only while run is high, held at zero otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)           r_dcnt <= '0;
    else if (!w_run_s)    r_dcnt <= '0;
    else if (w_auto_fire) r_dcnt <= '0;
    else                  r_dcnt <= r_dcnt + 1'b1;
  end

  // While running, the divider owns the step; the button FSM keeps tracking.
  assign w_step_fire = w_run_s ? w_auto_fire : w_btn_fire;
`else
  assign w_step_fire = w_btn_fire;
`endif

  // Registered step pulse and wrapping step counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_step       <= 1'b0;
      r_step_count <= '0;
    end else begin
      r_step <= w_step_fire;
      if (w_step_fire) r_step_count <= r_step_count + 16'd1;
    end
  end

  // Switch debounce: a new candidate restarts the count; a candidate stable
  // for DEBOUNCE_CYCLES is copied to the output while the count saturates.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cand   <= '0;
      r_scnt   <= '0;
      r_switch <= '0;
    end else if (r_sw_sync2 != r_cand) begin
      r_cand <= r_sw_sync2;
      r_scnt <= '0;
    end else if (r_scnt == DEB_LAST) begin
      r_switch <= r_cand;
    end else begin
      r_scnt <= r_scnt + 1'b1;
    end
  end

  assign bus.step       = r_step;
  assign bus.switch     = r_switch;
  assign bus.step_count = r_step_count;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Testbench for debug_step_ctrl with DEBOUNCE_CYCLES=4, RUN_DIV=8.
// Each expected step is queued (observation cycle + expected count) when the
// stimulus is driven; a monitor pops and compares when `step` is seen.
module tb_debug_step_ctrl;
  localparam int DEB = 4;
  localparam int CW  = 3;
  localparam int RD  = 8;

  logic clock;
  logic reset;
  debug_step_ctrl_if bus ();

  debug_step_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CW),
    .RUN_DIV        (RD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard: expected observation cycle and expected step_count per pulse.
  logic [31:0] exp_q[$];
  logic [15:0] cnt_q[$];
  logic [15:0] model_cnt;
  logic [31:0] mon_cyc;
  logic [15:0] mon_cnt;

  always @(negedge clock) begin
    if (bus.step === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL step_unexpected cyc=%0d actual step=1 required step=0", cyc);
      end else begin
        mon_cyc = exp_q.pop_front();
        mon_cnt = cnt_q.pop_front();
        if (cyc !== int'(mon_cyc)) begin
          errors++;
          $display("FAIL step_cycle actual=%0d required=%0d", cyc, mon_cyc);
        end
        checks++;
        if (bus.step_count !== mon_cnt) begin
          errors++;
          $display("FAIL step_count_at_pulse actual=%h required=%h", bus.step_count, mon_cnt);
        end
      end
    end
  end

  // Driver tasks
  task automatic push_step(input int at_cyc);
    model_cnt = model_cnt + 16'd1;
    exp_q.push_back(at_cyc);
    cnt_q.push_back(model_cnt);
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    bus.btn_step = 1'b0;
    bus.sw_raw   = '0;
`ifdef AUTO_RUN_EN
    bus.run      = 1'b0;
`endif
    model_cnt    = '0;
    exp_q.delete();
    cnt_q.delete();
    repeat (3) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    bus.btn_step = 1'b0;
    bus.sw_raw   = '0;
`ifdef AUTO_RUN_EN
    bus.run      = 1'b0;
`endif
    model_cnt    = '0;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if (bus.step !== 1'b0) begin errors++; $display("FAIL reset_step actual=%b required=0", bus.step); end
    checks++;
    if (bus.switch !== 6'd0) begin errors++; $display("FAIL reset_switch actual=%0d required=0", bus.switch); end
    checks++;
    if (bus.step_count !== 16'd0) begin errors++; $display("FAIL reset_step_count actual=%h required=0000", bus.step_count); end
    checks++;
    if (bus.dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state actual=%0d required=0", bus.dbg_state); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_press_hold();
    int c;
    @(negedge clock);
    c = cyc;
    bus.btn_step = 1'b1;
    push_step(c + 3 + DEB);
    repeat (2 + DEB) @(negedge clock);
    #1;
    checks++;
    if (bus.step !== 1'b0) begin errors++; $display("FAIL press_early actual=%b required=0", bus.step); end
    @(negedge clock);
    #1;
    checks++;
    if (bus.step !== 1'b1) begin errors++; $display("FAIL press_pulse actual=%b required=1", bus.step); end
    repeat (100) @(negedge clock);
    #1;
    checks++;
    if (bus.step_count !== 16'd1) begin errors++; $display("FAIL hold_count actual=%h required=0001", bus.step_count); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL hold_pending actual=%0d required=0", exp_q.size()); end
    bus.btn_step = 1'b0;
    repeat (3 + DEB + 2) @(negedge clock);
    #1;
    checks++;
    if (bus.dbg_state !== 2'd0) begin errors++; $display("FAIL release_idle actual=%0d required=0", bus.dbg_state); end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      bus.btn_step = ((i % 6) < 3);
    end
    @(negedge clock);
    bus.btn_step = 1'b0;
    repeat (10) @(negedge clock);
    #1;
    checks++;
    if (bus.step_count !== 16'd0) begin errors++; $display("FAIL glitch_count actual=%h required=0000", bus.step_count); end
  endtask

  task automatic test_multi_press();
    for (int p = 0; p < 3; p++) begin
      @(negedge clock);
      bus.btn_step = 1'b1;
      push_step(cyc + 3 + DEB);
      repeat (10) @(negedge clock);
      bus.btn_step = 1'b0;
      repeat (9) @(negedge clock);
    end
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if (bus.step_count !== 16'd3) begin errors++; $display("FAIL multi_count actual=%h required=0003", bus.step_count); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL multi_pending actual=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    @(negedge clock);
    dut.r_step_count = 16'hFFFF;
    model_cnt        = 16'hFFFF;
    @(negedge clock);
    bus.btn_step = 1'b1;
    push_step(cyc + 3 + DEB);
    repeat (10) @(negedge clock);
    bus.btn_step = 1'b0;
    repeat (10) @(negedge clock);
    #1;
    checks++;
    if (bus.step_count !== 16'h0000) begin errors++; $display("FAIL wrap_count actual=%h required=0000", bus.step_count); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_pending actual=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_switch();
    logic [5:0] v;
    @(negedge clock);
    bus.sw_raw = 6'd17;
    repeat (2 + DEB) @(negedge clock);
    #1;
    checks++;
    if (bus.switch !== 6'd0) begin errors++; $display("FAIL switch_early actual=%0d required=0", bus.switch); end
    @(negedge clock);
    #1;
    checks++;
    if (bus.switch !== 6'd17) begin errors++; $display("FAIL switch_settle actual=%0d required=17", bus.switch); end
    for (int i = 0; i < 20; i++) begin
      repeat (2) @(negedge clock);
      bus.sw_raw = (bus.sw_raw == 6'd17) ? 6'd18 : 6'd17;
      #1;
      checks++;
      if (bus.switch !== 6'd17) begin errors++; $display("FAIL switch_bounce i=%0d actual=%0d required=17", i, bus.switch); end
    end
    for (int k = 0; k < 4; k++) begin
      v = (k == 3) ? 6'd63 : 6'($urandom_range(0, 63));
      @(negedge clock);
      bus.sw_raw = v;
      repeat (3 + DEB + 1) @(negedge clock);
      #1;
      checks++;
      if (bus.switch !== v) begin errors++; $display("FAIL switch_code actual=%0d required=%0d", bus.switch, v); end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    bus.btn_step = 1'b1;
    repeat (5) @(negedge clock);
    #2;
    checks++;
    if (bus.dbg_state !== 2'd1) begin errors++; $display("FAIL mid_state actual=%0d required=1", bus.dbg_state); end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.step !== 1'b0) begin errors++; $display("FAIL mid_step actual=%b required=0", bus.step); end
    checks++;
    if (bus.switch !== 6'd0) begin errors++; $display("FAIL mid_switch actual=%0d required=0", bus.switch); end
    checks++;
    if (bus.step_count !== 16'd0) begin errors++; $display("FAIL mid_count actual=%h required=0000", bus.step_count); end
    checks++;
    if (bus.dbg_state !== 2'd0) begin errors++; $display("FAIL mid_reset_state actual=%0d required=0", bus.dbg_state); end
    model_cnt = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    push_step(cyc + 3 + DEB);
    repeat (12) @(negedge clock);
    #1;
    checks++;
    if (bus.step_count !== 16'd1) begin errors++; $display("FAIL mid_restart_count actual=%h required=0001", bus.step_count); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL mid_pending actual=%0d required=0", exp_q.size()); end
    bus.btn_step = 1'b0;
    repeat (3 + DEB + 2) @(negedge clock);
  endtask

  task automatic test_reset_async();
    @(negedge clock);
    bus.btn_step = 1'b1;
    push_step(cyc + 3 + DEB);
    repeat (3 + DEB) @(negedge clock);
    #2;
    checks++;
    if (bus.step !== 1'b1) begin errors++; $display("FAIL async_pre actual=%b required=1", bus.step); end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.step !== 1'b0) begin errors++; $display("FAIL async_drop actual=%b required=0", bus.step); end
    model_cnt    = '0;
    bus.btn_step = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
  endtask

`ifdef AUTO_RUN_EN
  task automatic test_auto_run();
    int c;
    do_reset();
    @(negedge clock);
    c = cyc;
    bus.run = 1'b1;
    for (int k = c + 2 + RD; k <= c + 40 + 2; k += RD) push_step(k);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (i == 5)  bus.btn_step = 1'b1;
      if (i == 15) bus.btn_step = 1'b0;
    end
    bus.run = 1'b0;
    repeat (20) @(negedge clock);
    #1;
    checks++;
    if (bus.step_count !== model_cnt) begin errors++; $display("FAIL run_count actual=%h required=%h", bus.step_count, model_cnt); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL run_pending actual=%0d required=0", exp_q.size()); end
  endtask
`endif

  // Sequence and final report
  initial begin
    test_reset();
    test_press_hold();
    test_glitch();
    test_multi_press();
    test_wrap();
    test_switch();
    test_reset_mid();
    test_reset_async();
`ifdef AUTO_RUN_EN
    test_auto_run();
`endif
    repeat (4) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL final_pending actual=%0d required=0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/debug_step_ctrl.md
# debug_step_ctrl

Front-panel input conditioner for the pipelined-processor board build. Synchronizes and debounces the step push-button into a single-cycle `step` pulse that clock-enables the processor, and debounces the 6-bit register-select switches into the `switch` bus consumed by the seven-segment display stage. Also keeps a wrapping count of issued steps for debug.

## Interface
- `DEBOUNCE_CYCLES`, 200000: consecutive stable cycles required before accepting an input change (2 ms at 100 MHz); must be ≥ 2.
- `CNT_W`, 18: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `RUN_DIV`, 50000000: cycles between auto-run steps; used only with `AUTO_RUN_EN`.
- `clock`  in  1  system clock; all logic on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `btn_step`  in  1  raw step push-button, active-high, asynchronous to `clock`.
- `sw_raw`  in  6  raw select switches, asynchronous.
- `run`  in  1  raw auto-run switch (present only with `AUTO_RUN_EN`).
- `step`  out  1  registered one-cycle step pulse.
- `switch`  out  6  debounced selector, registered.
- `step_count`  out  16  number of `step` pulses issued, wraps.

## Operation
- Every raw input passes through a two-flop synchronizer (reset value 0) before any use.
- Button FSM states (reset to IDLE; debounce counter `bcnt` resets to 0):
  - IDLE: synced btn=1 → PRESS_WAIT, `bcnt`←0.
  - PRESS_WAIT: btn=0 → IDLE. Else if `bcnt`==DEBOUNCE_CYCLES-1 → HELD and `step`←1. Else `bcnt`++.
  - HELD: btn=0 → RELEASE_WAIT, `bcnt`←0.
  - RELEASE_WAIT: btn=1 → HELD, with no new step. Else if `bcnt`==DEBOUNCE_CYCLES-1 → IDLE. Else `bcnt`++.
  - Exactly one step per debounced press. Holding the button never repeats. Glitches shorter than DEBOUNCE_CYCLES produce nothing.
- `step` is 0 on every edge except the accepting edge.
- Switch debounce uses a `cand` register (6 bits) and counter `scnt`, both reset to 0:
  - synced sw ≠ `cand`: `cand`←synced sw, `scnt`←0.
  - Else if `scnt`==DEBOUNCE_CYCLES-1: `switch`←`cand`, and `scnt` holds its value.
  - Else `scnt`++.
  - All 64 codes pass through unchanged; codes > 31 are handled downstream.
- `step_count` increments on each edge that registers `step`=1. It wraps 0xFFFF→0x0000.

## Timing
- Reset values: `step`=0, `switch`=0, `step_count`=0, FSM=IDLE, all synchronizers and counters 0. Assertion clears these immediately and asynchronously, including mid-debounce; `step` drops without waiting for an edge.
- Button latency, taking edge 1 as the first edge sampling `btn_step`=1 with the button held clean:
  - Synchronizer output is 1 after edge 2.
  - FSM enters PRESS_WAIT on edge 3.
  - `step`=1 in the cycle following edge 3+DEBOUNCE_CYCLES, for exactly one cycle.
- Switch latency: a clean change sampled at edge 1 appears on `switch` after edge 3+DEBOUNCE_CYCLES.
- Release then re-press: a new step needs a full RELEASE_WAIT (DEBOUNCE_CYCLES low cycles), then IDLE, then a full PRESS_WAIT.
- Release of `reset` mid-press: the FSM restarts from IDLE. A still-held button yields one step after the full latency.

## Configuration
- `AUTO_RUN_EN` defined:
  - Adds `run` (two-flop synced, not debounced) and a free-running divider `dcnt` (reset 0).
  - While synced run=1: `dcnt` counts 0..RUN_DIV-1 and `step`←1 on the wrap edge.
  - Button-originated steps are masked while run=1; the FSM still tracks the button.
  - run=0 clears `dcnt` to 0 every cycle.
  - Coincident sources give a single pulse, and `step_count` increments once.
- `AUTO_RUN_EN` undefined: no `run` port, no divider, and `RUN_DIV` is ignored.

## Test plan
(`DEBOUNCE_CYCLES`=4, `RUN_DIV`=8.)
- Reset low, then high; `btn_step`=1 held from edge 1 → `step` high only after edge 7; `step_count`=1; stays 1 while held 100 cycles.
- `btn_step` pulses high for 3 cycles, repeated with 3-cycle gaps for 40 cycles → no `step`; `step_count`=0.
- Press and release 3 times, each 10 cycles high and 10 low → 3 pulses; `step_count`=3. Preload 0xFFFF → next press gives 0x0000.
- `sw_raw` 0→6'd17 at edge 1 → `switch`=17 after edge 7. `sw_raw` toggles 17↔18 every 2 cycles → `switch` stays 17.
- Assert `reset` while in PRESS_WAIT with `bcnt`=2 → immediate `step`=0, `switch`=0, `step_count`=0; after release with the button still held → one step 7 edges later.
- `AUTO_RUN_EN`, `run`=1 for 40 cycles → `step` every 8 cycles, first 10 edges after `run` rises (2 sync + 8); button presses during that window → no extra pulses.
